lsu_mem_access: RTL and testbench

- Stage directly downstream of the LSU execute stage; takes its computed load address, or its store address/data/enable, and performs the data-memory transaction.
- Talks to data memory over a valid/ready request channel and a valid-only response channel, so memory latency is variable.
- Stalls the LSU pipe while a transaction is outstanding, returns load data to writeback through a valid/ready handshake, and flags misaligned and timed-out accesses.

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/lsu_timeout_ctr.sv | 29 ++
 rtl/lsu_mem_access.sv | 135 +++++++++++++
 tb/tb_lsu_mem_access.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the LSU memory-access stage.
// State encoding, default widths and the captured request bundle.
package lsu_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;
   localparam int REG_IDX_W  = 5;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      REQ       = 2'd1,
      WAIT_RESP = 2'd2,
      WB        = 2'd3
   } lsu_mem_state_e;

   typedef struct packed {
      logic                  we;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] wdata;
   } lsu_mem_req_t;

endpackage

// File: rtl/lsu_timeout_ctr.sv
// Clear/enable cycle counter with a terminal-count flag.
// Ports: clk, rst_n, clr, en in; tc out (count == TIMEOUT-1).
module lsu_timeout_ctr #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en && !tc) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tc = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/lsu_mem_access.sv
// LSU memory-access stage: one data-memory transaction at a time.
// Ports: ex_* op in, mem_req_*/mem_resp_* memory, wb_* result, err_* pulses.
module lsu_mem_access
   import lsu_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ex_valid,
   output logic                 ex_ready,
   input  logic                 ex_is_load,
   input  logic [ADDR_W-1:0]    ex_rd_addr,
   input  logic [ADDR_W-1:0]    ex_wr_addr,
   input  logic [DATA_W-1:0]    ex_wr_data,
   input  logic                 ex_wr_en,
   input  logic [REG_IDX_W-1:0] ex_rd,
   output logic                 mem_req_valid,
   input  logic                 mem_req_ready,
   output logic                 mem_req_we,
   output logic [ADDR_W-1:0]    mem_req_addr,
   output logic [DATA_W-1:0]    mem_req_wdata,
   input  logic                 mem_resp_valid,
   input  logic [DATA_W-1:0]    mem_resp_rdata,
   output logic                 wb_valid,
   input  logic                 wb_ready,
   output logic [REG_IDX_W-1:0] wb_rd,
   output logic [DATA_W-1:0]    wb_data,
   output logic                 err_misalign,
   output logic                 err_timeout
);

   lsu_mem_state_e       state_q, state_d;
   lsu_mem_req_t         req_q;
   logic [REG_IDX_W-1:0] rd_q;
   logic [DATA_W-1:0]    data_q;
   logic                 mis_q;

   logic [ADDR_W-1:0] sel_addr;
   logic              op_live;
   logic              accept;
   logic              mis_hit;
   logic              tc;

   // A store with its enable low is a bubble, not an op.
   assign sel_addr = ex_is_load ? ex_rd_addr : ex_wr_addr;
   assign op_live  = ex_valid && (ex_is_load || ex_wr_en);

   lsu_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_q != WAIT_RESP),
      .en    (state_q == WAIT_RESP),
      .tc    (tc)
   );

   always_comb begin
      state_d       = state_q;
      ex_ready      = 1'b0;
      mem_req_valid = 1'b0;
      wb_valid      = 1'b0;
      err_timeout   = 1'b0;
      accept        = 1'b0;
      mis_hit       = 1'b0;
      unique case (state_q)
         IDLE: begin
            ex_ready = 1'b1;
            if (op_live) begin
               if (sel_addr[1:0] != 2'b00) begin
                  mis_hit = 1'b1;
               end else begin
                  accept  = 1'b1;
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               state_d = req_q.we ? IDLE : WAIT_RESP;
            end
         end
         WAIT_RESP: begin
            // A response on the terminal cycle beats the timeout.
            if (mem_resp_valid) begin
               state_d = WB;
            end else if (tc) begin
               err_timeout = 1'b1;
               state_d     = IDLE;
            end
         end
         WB: begin
            wb_valid = 1'b1;
            if (wb_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q   <= '0;
         rd_q    <= '0;
         data_q  <= '0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mis_q   <= mis_hit;
         if (accept) begin
            req_q.we    <= !ex_is_load;
            req_q.addr  <= sel_addr;
            req_q.wdata <= ex_wr_data;
            rd_q        <= ex_rd;
         end
         if (state_q == WAIT_RESP && mem_resp_valid) begin
            data_q <= mem_resp_rdata;
         end
      end
   end

   assign mem_req_we    = req_q.we;
   assign mem_req_addr  = req_q.addr;
   assign mem_req_wdata = req_q.wdata;
   assign wb_rd         = rd_q;
   assign wb_data       = data_q;
   assign err_misalign  = mis_q;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed bench for lsu_mem_access with TIMEOUT = 8.
// Drives on the falling edge, checks 1ns later.
module tb_lsu_mem_access;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid;
   logic        ex_ready;
   logic        ex_is_load;
   logic [31:0] ex_rd_addr;
   logic [31:0] ex_wr_addr;
   logic [31:0] ex_wr_data;
   logic        ex_wr_en;
   logic [4:0]  ex_rd;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_we;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_wdata;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_rdata;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        err_misalign;
   logic        err_timeout;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   lsu_mem_access #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT (8)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ex_valid       (ex_valid),
      .ex_ready       (ex_ready),
      .ex_is_load     (ex_is_load),
      .ex_rd_addr     (ex_rd_addr),
      .ex_wr_addr     (ex_wr_addr),
      .ex_wr_data     (ex_wr_data),
      .ex_wr_en       (ex_wr_en),
      .ex_rd          (ex_rd),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_we     (mem_req_we),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wdata  (mem_req_wdata),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_rdata (mem_resp_rdata),
      .wb_valid       (wb_valid),
      .wb_ready       (wb_ready),
      .wb_rd          (wb_rd),
      .wb_data        (wb_data),
      .err_misalign   (err_misalign),
      .err_timeout    (err_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, ".ex_ready"}, 32'(ex_ready), 32'd1);
      chk({tag, ".req_v"}, 32'(mem_req_valid), 32'd0);
      chk({tag, ".wb_v"}, 32'(wb_valid), 32'd0);
      chk({tag, ".err_t"}, 32'(err_timeout), 32'd0);
   endtask

   task automatic issue_load(input logic [31:0] a, input logic [4:0] rd);
      cyc();
      ex_valid   = 1'b1;
      ex_is_load = 1'b1;
      ex_rd_addr = a;
      ex_rd      = rd;
      #1;
      chk("ld.accept_ready", 32'(ex_ready), 32'd1);
      cyc();
      ex_valid      = 1'b0;
      mem_req_ready = 1'b1;
      #1;
      chk("ld.req_v", 32'(mem_req_valid), 32'd1);
      chk("ld.req_we", 32'(mem_req_we), 32'd0);
      chk("ld.req_addr", mem_req_addr, a);
   endtask

   initial begin
      rst_n          = 1'b0;
      ex_valid       = 1'b0;
      ex_is_load     = 1'b0;
      ex_rd_addr     = '0;
      ex_wr_addr     = '0;
      ex_wr_data     = '0;
      ex_wr_en       = 1'b0;
      ex_rd          = '0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = '0;
      wb_ready       = 1'b0;

      cyc();
      #1;
      idle_chk("rst");
      chk("rst.addr", mem_req_addr, 32'h0);
      chk("rst.err_m", 32'(err_misalign), 32'd0);
      cyc();
      rst_n = 1'b1;

      // store with ready held low for three cycles
      cyc();
      ex_valid   = 1'b1;
      ex_is_load = 1'b0;
      ex_wr_addr = 32'h100;
      ex_wr_data = 32'hDEADBEEF;
      ex_wr_en   = 1'b1;
      #1;
      chk("st.accept_ready", 32'(ex_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         cyc();
         ex_valid      = 1'b0;
         ex_wr_en      = 1'b0;
         mem_req_ready = (i == 3);
         #1;
         chk("st.req_v", 32'(mem_req_valid), 32'd1);
         chk("st.req_we", 32'(mem_req_we), 32'd1);
         chk("st.addr", mem_req_addr, 32'h100);
         chk("st.wdata", mem_req_wdata, 32'hDEADBEEF);
         chk("st.ex_ready", 32'(ex_ready), 32'd0);
         chk("st.wb_v", 32'(wb_valid), 32'd0);
      end
      cyc();
      mem_req_ready = 1'b0;
      #1;
      idle_chk("st.done");

      // load, response after 5 wait cycles, wb stall 2 cycles
      issue_load(32'h200, 5'd7);
      for (int i = 0; i < 5; i++) begin
         cyc();
         mem_req_ready  = 1'b0;
         mem_resp_valid = (i == 4);
         mem_resp_rdata = (i == 4) ? 32'hCAFEF00D : 32'h0BAD0BAD;
         #1;
         chk("ld.wait_wb_v", 32'(wb_valid), 32'd0);
         chk("ld.wait_ready", 32'(ex_ready), 32'd0);
      end
      for (int i = 0; i < 3; i++) begin
         cyc();
         mem_resp_valid = 1'b0;
         mem_resp_rdata = 32'h0;
         wb_ready       = (i == 2);
         #1;
         chk("ld.wb_v", 32'(wb_valid), 32'd1);
         chk("ld.wb_rd", 32'(wb_rd), 32'd7);
         chk("ld.wb_data", wb_data, 32'hCAFEF00D);
         chk("ld.wb_ex_ready", 32'(ex_ready), 32'd0);
      end
      cyc();
      wb_ready = 1'b0;
      #1;
      idle_chk("ld.done");

      // misaligned load
      cyc();
      ex_valid   = 1'b1;
      ex_is_load = 1'b1;
      ex_rd_addr = 32'h203;
      #1;
      chk("mis.ready", 32'(ex_ready), 32'd1);
      chk("mis.err0", 32'(err_misalign), 32'd0);
      cyc();
      ex_valid = 1'b0;
      #1;
      chk("mis.err1", 32'(err_misalign), 32'd1);
      chk("mis.req_v", 32'(mem_req_valid), 32'd0);
      chk("mis.ready1", 32'(ex_ready), 32'd1);
      cyc();
      #1;
      chk("mis.err2", 32'(err_misalign), 32'd0);
      chk("mis.req_v2", 32'(mem_req_valid), 32'd0);

      // timeout with no response
      issue_load(32'h300, 5'd9);
      for (int i = 1; i <= 8; i++) begin
         cyc();
         mem_req_ready = 1'b0;
         #1;
         chk("tmo.err", 32'(err_timeout), (i == 8) ? 32'd1 : 32'd0);
         chk("tmo.wb_v", 32'(wb_valid), 32'd0);
      end
      cyc();
      #1;
      idle_chk("tmo.after");

      // response on the terminal cycle wins
      issue_load(32'h304, 5'd10);
      for (int i = 1; i <= 8; i++) begin
         cyc();
         mem_req_ready  = 1'b0;
         mem_resp_valid = (i == 8);
         mem_resp_rdata = 32'h12345678;
         #1;
         chk("race.err", 32'(err_timeout), 32'd0);
      end
      cyc();
      mem_resp_valid = 1'b0;
      wb_ready       = 1'b1;
      #1;
      chk("race.wb_v", 32'(wb_valid), 32'd1);
      chk("race.wb_rd", 32'(wb_rd), 32'd10);
      chk("race.wb_data", wb_data, 32'h12345678);
      cyc();
      wb_ready = 1'b0;
      #1;
      idle_chk("race.done");

      // reset in the middle of WAIT_RESP, then a stray response
      issue_load(32'h400, 5'd4);
      cyc();
      mem_req_ready = 1'b0;
      cyc();
      rst_n = 1'b0;
      #1;
      idle_chk("mrst");
      chk("mrst.addr", mem_req_addr, 32'h0);
      chk("mrst.wb_rd", 32'(wb_rd), 32'd0);
      chk("mrst.err_m", 32'(err_misalign), 32'd0);
      cyc();
      rst_n = 1'b1;
      cyc();
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 32'hFFFF0000;
      cyc();
      mem_resp_valid = 1'b0;
      #1;
      idle_chk("stray");
      chk("stray.wb_data", wb_data, 32'h0);
      cyc();
      #1;
      idle_chk("stray2");

      // disabled store then load with ex_valid held high
      cyc();
      ex_valid   = 1'b1;
      ex_is_load = 1'b0;
      ex_wr_en   = 1'b0;
      ex_wr_addr = 32'h500;
      #1;
      chk("b2b.ready0", 32'(ex_ready), 32'd1);
      cyc();
      ex_is_load = 1'b1;
      ex_rd_addr = 32'h600;
      ex_rd      = 5'd3;
      #1;
      chk("b2b.ready1", 32'(ex_ready), 32'd1);
      chk("b2b.req_v0", 32'(mem_req_valid), 32'd0);
      cyc();
      ex_valid      = 1'b0;
      mem_req_ready = 1'b1;
      #1;
      chk("b2b.req_v", 32'(mem_req_valid), 32'd1);
      chk("b2b.addr", mem_req_addr, 32'h600);
      chk("b2b.we", 32'(mem_req_we), 32'd0);
      cyc();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 32'h00C0FFEE;
      cyc();
      mem_resp_valid = 1'b0;
      wb_ready       = 1'b1;
      #1;
      chk("b2b.wb_v", 32'(wb_valid), 32'd1);
      chk("b2b.wb_rd", 32'(wb_rd), 32'd3);
      chk("b2b.wb_data", wb_data, 32'h00C0FFEE);
      cyc();
      wb_ready = 1'b0;
      #1;
      idle_chk("b2b.done");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
